// File: rtl/fp32_serial_subtractor_if.sv
// fp32_serial_subtractor_if: operand/result valid-ready streams of the serial FP32 subtractor
interface fp32_serial_subtractor_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] O;
    modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, O);
    modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, O);
endinterface

// File: rtl/fp32_serial_subtractor.sv
// fp32_serial_subtractor: multi-cycle FP32 O = A - B with bit-serial alignment and normalisation
module fp32_serial_subtractor (
    input logic CLK,
    input logic rst,
    fp32_serial_subtractor_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;
    state_t      r_state;
    logic        r_sl;
    logic        r_ss;
    logic [7:0]  r_exp;
    logic [23:0] r_ml;
    logic [23:0] r_ms;
    logic [4:0]  r_cnt;
    logic [24:0] r_m;
    logic [31:0] r_o;
    logic        r_out_valid;
    logic [31:0] w_bn;
    logic        w_a_nan, w_b_nan, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_special;
    logic [31:0] w_spec_o;
    logic [7:0]  w_ea, w_eb, w_el, w_es, w_diff;
    logic [23:0] w_ma, w_mb;
    logic        w_a_ge;
    logic [4:0]  w_k;
    logic        w_norm_done;
    logic [31:0] w_pack;
    assign w_bn     = {~bus.B[31], bus.B[30:0]};
    assign w_a_nan  = (&bus.A[30:23]) && (|bus.A[22:0]);
    assign w_b_nan  = (&bus.B[30:23]) && (|bus.B[22:0]);
    assign w_a_inf  = (&bus.A[30:23]) && !(|bus.A[22:0]);
    assign w_b_inf  = (&bus.B[30:23]) && !(|bus.B[22:0]);
    assign w_a_zero = !(|bus.A[30:0]);
    assign w_b_zero = !(|bus.B[30:0]);
    assign w_special = w_a_nan || w_b_nan || w_a_zero || w_b_zero || w_a_inf || w_b_inf;
    // First match wins; B' is B with its sign flipped
    assign w_spec_o = (w_a_nan || w_b_zero) ? bus.A :
                      (w_b_nan || w_a_zero) ? w_bn :
                      (w_a_inf && w_b_inf && (bus.A[31] != w_bn[31])) ? 32'h7FC0_0000 :
                      w_a_inf ? bus.A : w_bn;
    assign w_ea   = (bus.A[30:23] == 8'd0) ? 8'd1 : bus.A[30:23];
    assign w_eb   = (bus.B[30:23] == 8'd0) ? 8'd1 : bus.B[30:23];
    assign w_ma   = {|bus.A[30:23], bus.A[22:0]};
    assign w_mb   = {|bus.B[30:23], bus.B[22:0]};
    assign w_a_ge = {w_ea, w_ma} >= {w_eb, w_mb};
    assign w_el   = w_a_ge ? w_ea : w_eb;
    assign w_es   = w_a_ge ? w_eb : w_ea;
    assign w_diff = w_el - w_es;
    assign w_k    = (w_diff > 8'd25) ? 5'd25 : w_diff[4:0];
    assign w_norm_done = !r_m[24] && (r_m[23] || (r_exp == 8'd1) || (r_m == 25'd0));
    assign w_pack = (r_m == 25'd0) ? 32'h0000_0000 :
                    (r_exp == 8'hFF) ? {r_sl, 8'hFF, 23'd0} :
                    !r_m[23] ? {r_sl, 8'd0, r_m[22:0]} : {r_sl, r_exp, r_m[22:0]};
    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.O         = r_o;
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sl        <= 1'b0;
            r_ss        <= 1'b0;
            r_exp       <= 8'd0;
            r_ml        <= 24'd0;
            r_ms        <= 24'd0;
            r_cnt       <= 5'd0;
            r_m         <= 25'd0;
            r_o         <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    if (w_special) begin
                        r_o         <= w_spec_o;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_sl    <= w_a_ge ? bus.A[31] : w_bn[31];
                        r_ss    <= w_a_ge ? w_bn[31] : bus.A[31];
                        r_exp   <= w_el;
                        r_ml    <= w_a_ge ? w_ma : w_mb;
                        r_ms    <= w_a_ge ? w_mb : w_ma;
                        r_cnt   <= w_k;
                        r_state <= ALIGN;
                    end
                end
                ALIGN: if (r_cnt == 5'd0) begin
                    r_state <= ADDSUB;
                end else begin
                    r_ms  <= r_ms >> 1;
                    r_cnt <= r_cnt - 5'd1;
                end
                ADDSUB: begin
                    r_m     <= (r_sl == r_ss) ? {1'b0, r_ml} + {1'b0, r_ms} : {1'b0, r_ml} - {1'b0, r_ms};
                    r_state <= NORM;
                end
                NORM: if (r_m[24]) begin
                    r_m   <= r_m >> 1;
                    r_exp <= r_exp + 8'd1;
                end else if (w_norm_done) begin
                    r_o         <= w_pack;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end else begin
                    r_m   <= r_m << 1;
                    r_exp <= r_exp - 8'd1;
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_serial_subtractor.sv
// tb_fp32_serial_subtractor: directed vectors, handshake/reset sequences and randomized ops against a reference model
module tb_fp32_serial_subtractor;
    logic CLK = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    fp32_serial_subtractor_if bus ();
    fp32_serial_subtractor dut (.CLK(CLK), .rst(rst), .bus(bus));
    always #5 CLK = ~CLK;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        int          lat;
    } vec_t;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Reference: real-valued rules from the format description, one shot per operation
    function automatic void model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] o, output int lat);
        logic [31:0] bn;
        logic an, bnn, az, bz, ai, bi, sl, ss;
        int ea, eb, el, es, k, e, n;
        longint ma, mb, ml, ms, m;
        bn  = {~b[31], b[30:0]};
        an  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bnn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        az  = a[30:0] == 0;
        bz  = b[30:0] == 0;
        lat = 1;
        if (an || bz) o = a;
        else if (bnn || az) o = bn;
        else if (ai && bi && (a[31] != bn[31])) o = 32'h7FC00000;
        else if (ai) o = a;
        else if (bi) o = bn;
        else begin
            ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
            eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
            ma = longint'(a[22:0]) + ((a[30:23] != 0) ? 64'd8388608 : 64'd0);
            mb = longint'(b[22:0]) + ((b[30:23] != 0) ? 64'd8388608 : 64'd0);
            if (longint'(ea) * 16777216 + ma >= longint'(eb) * 16777216 + mb) begin
                el = ea; es = eb; ml = ma; ms = mb; sl = a[31]; ss = bn[31];
            end else begin
                el = eb; es = ea; ml = mb; ms = ma; sl = bn[31]; ss = a[31];
            end
            k = el - es;
            if (k > 25) k = 25;
            ms = ms >> k;
            m = (sl == ss) ? ml + ms : ml - ms;
            e = el;
            n = 0;
            if (m >= 64'd16777216) begin
                m = m >> 1; e++; n = 1;
            end else begin
                while (m != 0 && m < 64'd8388608 && e > 1) begin
                    m = m << 1; e--; n++;
                end
            end
            if (m == 0) o = 32'h0;
            else if (e == 255) o = {sl, 8'hFF, 23'd0};
            else if (m < 64'd8388608) o = {sl, 8'd0, m[22:0]};
            else o = {sl, e[7:0], m[22:0]};
            lat = k + n + 4;
        end
    endfunction
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] o, output int lat);
        int w;
        w = 0;
        @(negedge CLK);
        while (!bus.in_ready && w < 100) begin
            @(negedge CLK);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        wait_out(lat);
        o = bus.O;
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1 bus.out_ready = 1'b0;
    endtask
    initial begin
        vec_t vecs[13];
        logic [31:0] o, eo, a, b;
        int lat, elat, mode, ebx;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = 32'h0;
        bus.B = 32'h0;
        vecs[0]  = '{32'h3F800000, 32'h3F000000, 32'h3F000000, 6};
        vecs[1]  = '{32'h40400000, 32'hBF800000, 32'h40800000, 6};
        vecs[2]  = '{32'h40490FDB, 32'h40490FDB, 32'h00000000, 4};
        vecs[3]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1};
        vecs[4]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1};
        vecs[5]  = '{32'h00000000, 32'h3F800000, 32'hBF800000, 1};
        vecs[6]  = '{32'h00800000, 32'h00400000, 32'h00400000, 4};
        vecs[7]  = '{32'h4B800000, 32'h33800000, 32'h4B800000, 29};
        vecs[8]  = '{32'h3F800000, 32'h00000000, 32'h3F800000, 1};
        vecs[9]  = '{32'h3F800000, 32'h7FC00001, 32'hFFC00001, 1};
        vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h7F800000, 1};
        vecs[11] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 5};
        vecs[12] = '{32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 28};
        repeat (3) @(negedge CLK);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset O", bus.O, 32'h0);
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        #1 check("in_ready after release", {31'd0, bus.in_ready}, 32'd1);
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, o, lat);
            check($sformatf("vec%0d O", i), o, vecs[i].o);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
        end
        // Stall the consumer while a second pair waits on the input
        @(negedge CLK);
        bus.in_valid = 1'b1;
        bus.A = 32'h3F800000;
        bus.B = 32'h3F000000;
        @(posedge CLK);
        #1;
        bus.A = 32'h40400000;
        bus.B = 32'hBF800000;
        wait_out(lat);
        check("stall first O", bus.O, 32'h3F000000);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check($sformatf("stall hold c%0d", c), {bus.O[31:2], bus.out_valid, bus.in_ready}, {30'h0FC00000, 1'b1, 1'b0});
        end
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1 bus.out_ready = 1'b0;
        check("release idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        @(posedge CLK);
        #1 bus.in_valid = 1'b0;
        wait_out(lat);
        check("back-to-back O", bus.O, 32'h40800000);
        check("back-to-back latency", 32'(lat), 32'd6);
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1 bus.out_ready = 1'b0;
        // Abort an operation two cycles in
        @(negedge CLK);
        bus.in_valid = 1'b1;
        bus.A = 32'h3F800000;
        bus.B = 32'h3F000000;
        @(posedge CLK);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(negedge CLK);
        rst = 1'b1;
        #1;
        check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort O", bus.O, 32'h0);
        check("abort in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        #1 check("abort release in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (8) @(negedge CLK);
        check("abort no output", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 80; i++) begin
            mode = $urandom_range(0, 9);
            a = $urandom;
            if (mode == 0) b = $urandom;
            else begin
                a[30:23] = 8'($urandom_range(0, 254));
                ebx = int'(a[30:23]) + $urandom_range(0, 60) - 30;
                ebx = (ebx < 0) ? 0 : (ebx > 254) ? 254 : ebx;
                b = {1'($urandom), ebx[7:0], 23'($urandom)};
                if (mode == 9) b = {1'($urandom), a[30:1], 1'($urandom)};
            end
            model(a, b, eo, elat);
            run_op(a, b, o, lat);
            check($sformatf("rand%0d O a=%h b=%h", i, a, b), o, eo);
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(elat));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
